amiq_fifo_read_packer: RTL and testbench

- Read-side consumer stage sitting directly downstream of the FIFO read port (rd_en / rd_data).
- Pulls M-bit words from the FIFO whenever data is available and packs RATIO consecutive words into one wide output word.
- Presents the wide word on a valid/ready handshake to the next block.
- Guarantees rd_en is never asserted while the FIFO reports empty.

---
 rtl/amiq_fifo_read_packer.sv | 86 ++++++++
 tb/tb_amiq_fifo_read_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/amiq_fifo_read_packer.sv
// rtl/amiq_fifo_read_packer.sv - packs RATIO consecutive FIFO read words into one wide valid/ready word
// Optional partial-word flush (flush/out_count ports) enabled by `define AMIQ_FIFO_READ_PACKER_FLUSH_EN.
module amiq_fifo_read_packer #(
   parameter int M     = 8,
   parameter int RATIO = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       empty,
   output logic                       rd_en,
   input  logic [M-1:0]               rd_data,
   output logic                       out_valid,
   input  logic                       out_ready,
`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
   input  logic                       flush,
   output logic [$clog2(RATIO+1)-1:0] out_count,
`endif
   output logic [M*RATIO-1:0]         out_data
);

   localparam int CW = $clog2(RATIO+1);
   localparam logic [CW-1:0] FULL = CW'(RATIO);

   logic [CW-1:0]      issued;
   logic [CW-1:0]      captured;
   logic               in_flight;
   logic [M*RATIO-1:0] acc;
   logic               issue_ok;
   logic               fire;
   logic               transfer;

`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
   // A flush waits for the last in-flight word so the partial word is complete.
   assign issue_ok = !flush;
   assign fire     = (captured == FULL) || (flush && !in_flight && (captured != '0));
`else
   assign issue_ok = 1'b1;
   assign fire     = (captured == FULL);
`endif

   assign rd_en    = !empty && (issued < FULL) && issue_ok && !rst;
   assign transfer = fire && (!out_valid || out_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued    <= '0;
         captured  <= '0;
         in_flight <= 1'b0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
         out_count <= '0;
`endif
      end else begin
         in_flight <= rd_en;
         if (transfer) begin
            // issued==captured here and no read is outstanding, so nothing is lost.
            issued    <= '0;
            captured  <= '0;
            acc       <= '0;
            out_data  <= acc;
            out_valid <= 1'b1;
`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
            out_count <= captured;
`endif
         end else begin
            if (rd_en) begin
               issued <= issued + 1'b1;
            end
            if (in_flight) begin
               for (int i = 0; i < RATIO; i++) begin
                  if (captured == CW'(i)) begin
                     acc[i*M +: M] <= rd_data;
                  end
               end
               captured <= captured + 1'b1;
            end
            if (out_valid && out_ready) begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_amiq_fifo_read_packer.sv
// tb/tb_amiq_fifo_read_packer.sv - directed self-checking bench for amiq_fifo_read_packer (M=8, RATIO=4)
// Flush scenario is exercised only when AMIQ_FIFO_READ_PACKER_FLUSH_EN is defined.
module tb_amiq_fifo_read_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        empty = 1'b1;
   logic        rd_en;
   logic [7:0]  rd_data = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
   logic        flush = 1'b0;
   logic [2:0]  out_count;
`endif

   logic [7:0]  q[$];
   logic [31:0] got[$];
   int          reads = 0;
   int          viol = 0;
   int          valid_cycles = 0;
   int          passed = 0;
   int          total = 0;
   bit          stall_mode = 1'b0;
   logic        rd_en_s = 1'b0;
   bit          ok;

   amiq_fifo_read_packer #(.M(8), .RATIO(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .empty     (empty),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
      .flush     (flush),
      .out_count (out_count),
`endif
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   // FIFO model: a read granted at an edge presents its word 1ns later, for capture on the next edge.
   always @(posedge clk) begin
      #1;
      if (rd_en_s) begin
         reads++;
         if (q.size() > 0) rd_data = q.pop_front();
      end
      empty = (q.size() == 0) || (stall_mode && rd_en_s);
   end

   always @(negedge clk) begin
      rd_en_s = rd_en;
      if (rd_en && empty) viol++;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) got.push_back(out_data);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_beats(input int n, input int budget, output bit done);
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (got.size() >= n) begin
            done = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_stats();
      got.delete();
      reads = 0;
      valid_cycles = 0;
   endtask

   task automatic test_reset();
      out_ready = 1'b1;
      q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
      @(negedge clk); #1;
      total++; if (empty !== 1'b0) $display("FAIL reset_fifo_ready: empty=%b required 0", empty); else passed++;
      total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b required 0", rd_en); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else passed++;
      total++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h required 00000000", out_data); else passed++;
      clear_stats();
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      total++; if (rd_en !== 1'b1) $display("FAIL reset_release_rd_en: got %b required 1", rd_en); else passed++;
   endtask

   task automatic test_basic_pack();
      wait_beats(1, 30, ok);
      total++; if (ok !== 1'b1) $display("FAIL basic_timeout: beats %0d required 1", got.size()); else passed++;
      total++; if (got.size() > 0 && got[0] !== 32'h44332211) $display("FAIL basic_data: got %h required 44332211", got[0]); else passed++;
      total++; if (reads !== 4) $display("FAIL basic_reads: got %0d required 4", reads); else passed++;
`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
      total++; if (out_count !== 3'd4) $display("FAIL basic_out_count: got %0d required 4", out_count); else passed++;
`endif
      repeat (4) @(negedge clk);
      #1;
      total++; if (valid_cycles !== 1) $display("FAIL basic_valid_cycles: got %0d required 1", valid_cycles); else passed++;
      total++; if (got.size() !== 1) $display("FAIL basic_beats: got %0d required 1", got.size()); else passed++;
   endtask

   task automatic test_empty_stall();
      @(posedge clk); #1;
      clear_stats();
      viol = 0;
      stall_mode = 1'b1;
      q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
      wait_beats(1, 40, ok);
      total++; if (ok !== 1'b1) $display("FAIL stall_timeout: beats %0d required 1", got.size()); else passed++;
      total++; if (got.size() > 0 && got[0] !== 32'h44332211) $display("FAIL stall_data: got %h required 44332211", got[0]); else passed++;
      total++; if (reads !== 4) $display("FAIL stall_reads: got %0d required 4", reads); else passed++;
      total++; if (viol !== 0) $display("FAIL stall_rd_en_while_empty: got %0d required 0", viol); else passed++;
      stall_mode = 1'b0;
   endtask

   task automatic test_back_pressure();
      repeat (3) @(posedge clk);
      #1;
      clear_stats();
      out_ready = 1'b0;
      for (int i = 1; i <= 12; i++) q.push_back(8'(i));
      repeat (40) @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b required 1", out_valid); else passed++;
      total++; if (out_data !== 32'h04030201) $display("FAIL bp_first_word: got %h required 04030201", out_data); else passed++;
      total++; if (reads !== 8) $display("FAIL bp_reads_capped: got %0d required 8", reads); else passed++;
      total++; if (rd_en !== 1'b0) $display("FAIL bp_rd_en_low: got %b required 0", rd_en); else passed++;
      repeat (5) @(negedge clk);
      #1;
      total++; if (out_data !== 32'h04030201) $display("FAIL bp_held_stable: got %h required 04030201", out_data); else passed++;
      total++; if (reads !== 8) $display("FAIL bp_reads_still: got %0d required 8", reads); else passed++;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_beats(3, 40, ok);
      total++; if (ok !== 1'b1) $display("FAIL bp_timeout: beats %0d required 3", got.size()); else passed++;
      total++; if (got.size() > 0 && got[0] !== 32'h04030201) $display("FAIL bp_beat0: got %h required 04030201", got[0]); else passed++;
      total++; if (got.size() > 1 && got[1] !== 32'h08070605) $display("FAIL bp_beat1: got %h required 08070605", got[1]); else passed++;
      total++; if (got.size() > 2 && got[2] !== 32'h0C0B0A09) $display("FAIL bp_beat2: got %h required 0c0b0a09", got[2]); else passed++;
      total++; if (reads !== 12) $display("FAIL bp_reads_total: got %0d required 12", reads); else passed++;
   endtask

   task automatic test_reset_mid_word();
      repeat (4) @(posedge clk);
      #1;
      clear_stats();
      q.push_back(8'hB1); q.push_back(8'hB2);
      repeat (8) @(negedge clk);
      #1;
      total++; if (got.size() !== 0) $display("FAIL midrst_no_partial: beats %0d required 0", got.size()); else passed++;
      @(posedge clk);
      #3;
      rst = 1'b1;
      q.push_back(8'hA1); q.push_back(8'hA2); q.push_back(8'hA3); q.push_back(8'hA4);
      #1;
      total++; if (out_data !== 32'h0) $display("FAIL midrst_async_clear: got %h required 00000000", out_data); else passed++;
      repeat (2) @(negedge clk);
      #1;
      total++; if (rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b required 0", rd_en); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b required 0", out_valid); else passed++;
      clear_stats();
      @(posedge clk); #1;
      rst = 1'b0;
      wait_beats(1, 30, ok);
      total++; if (ok !== 1'b1) $display("FAIL midrst_timeout: beats %0d required 1", got.size()); else passed++;
      total++; if (got.size() > 0 && got[0] !== 32'hA4A3A2A1) $display("FAIL midrst_data: got %h required a4a3a2a1", got[0]); else passed++;
      total++; if (reads !== 4) $display("FAIL midrst_reads: got %0d required 4", reads); else passed++;
   endtask

`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
   task automatic test_flush();
      repeat (4) @(posedge clk);
      #1;
      clear_stats();
      q.push_back(8'h55); q.push_back(8'h66);
      repeat (8) @(negedge clk);
      #1;
      total++; if (got.size() !== 0) $display("FAIL flush_no_early: beats %0d required 0", got.size()); else passed++;
      @(posedge clk); #1;
      flush = 1'b1;
      q.push_back(8'h77);
      wait_beats(1, 20, ok);
      total++; if (ok !== 1'b1) $display("FAIL flush_timeout: beats %0d required 1", got.size()); else passed++;
      total++; if (got.size() > 0 && got[0] !== 32'h00006655) $display("FAIL flush_data: got %h required 00006655", got[0]); else passed++;
      total++; if (out_count !== 3'd2) $display("FAIL flush_out_count: got %0d required 2", out_count); else passed++;
      repeat (5) @(negedge clk);
      #1;
      total++; if (reads !== 2) $display("FAIL flush_blocks_rd_en: reads %0d required 2", reads); else passed++;
      total++; if (got.size() !== 1) $display("FAIL flush_single_beat: beats %0d required 1", got.size()); else passed++;
      flush = 1'b0;
   endtask
`endif

   task automatic test_protocol();
      total++; if (viol !== 0) $display("FAIL protocol_rd_en_while_empty: got %0d required 0", viol); else passed++;
   endtask

   initial begin
      viol = 0;
      test_reset();
      test_basic_pack();
      test_empty_stall();
      test_back_pressure();
      test_reset_mid_word();
`ifdef AMIQ_FIFO_READ_PACKER_FLUSH_EN
      test_flush();
`endif
      test_protocol();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
